// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_controller
// Brief   : Main sequencing FSM for the multi-cycle RV32I datapath.
// Revision: 1.0 - initial release
// ============================================================================
module multicycle_controller #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       neg,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       halted
);

  localparam logic [6:0] c_OP_LW     = 7'b0000011;
  localparam logic [6:0] c_OP_SW     = 7'b0100011;
  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_I      = 7'b0010011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;

  localparam logic [2:0] c_ALU_ADD = 3'b000;
  localparam logic [2:0] c_ALU_SUB = 3'b001;
  localparam logic [2:0] c_ALU_AND = 3'b010;
  localparam logic [2:0] c_ALU_OR  = 3'b011;
  localparam logic [2:0] c_ALU_SLT = 3'b100;
  localparam logic [2:0] c_ALU_XOR = 3'b101;

  localparam logic [2:0] c_IMM_I = 3'b000;
  localparam logic [2:0] c_IMM_S = 3'b001;
  localparam logic [2:0] c_IMM_B = 3'b010;
  localparam logic [2:0] c_IMM_J = 3'b011;
  localparam logic [2:0] c_IMM_U = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_EXECJALR = 4'd9,
    S_JAL      = 4'd10,
    S_BRANCH   = 4'd11,
    S_LUI      = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] w_alu_f3;
  logic       w_taken;
  logic       w_unused;

  // Only funct7[5] distinguishes sub from add among supported ops.
  assign w_unused = ^{funct7[6], funct7[4:0]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // funct3 -> ALU operation shared by register and immediate ALU forms.
  always_comb begin
    w_alu_f3 = c_ALU_ADD;
    case (funct3)
      3'b111:  w_alu_f3 = c_ALU_AND;
      3'b110:  w_alu_f3 = c_ALU_OR;
      3'b010:  w_alu_f3 = c_ALU_SLT;
      3'b100:  w_alu_f3 = c_ALU_XOR;
      default: w_alu_f3 = c_ALU_ADD;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'b000:  w_taken = zero;
      3'b001:  w_taken = ~zero;
      3'b100:  w_taken = neg;
      3'b101:  w_taken = ~neg;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          c_OP_LW, c_OP_SW: w_next = S_MEMADR;
          c_OP_R:           w_next = S_EXECR;
          c_OP_I:           w_next = S_EXECI;
          c_OP_BRANCH:      w_next = S_BRANCH;
          c_OP_JAL:         w_next = S_JAL;
          c_OP_JALR:        w_next = S_EXECJALR;
          c_OP_LUI:         w_next = S_LUI;
          default:          w_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (opcode == c_OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_EXECJALR: w_next = S_JAL;
      S_JAL:      w_next = S_ALUWB;
      S_BRANCH:   w_next = S_FETCH;
      S_LUI:      w_next = S_FETCH;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_FETCH;
    endcase
  end

  // Outputs are forced to zero while rst is high so an in-flight write is dropped.
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = c_ALU_ADD;
    ImmSrc     = c_IMM_I;
    RegWrite   = 1'b0;
    halted     = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          ImmSrc  = (opcode == c_OP_JAL) ? c_IMM_J : c_IMM_B;
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ImmSrc  = (opcode == c_OP_SW) ? c_IMM_S : c_IMM_I;
        end
        S_MEMREAD: AdrSrc = 1'b1;
        S_MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        S_MEMWRITE: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXECR: begin
          ALUSrcA    = 2'b10;
          ALUControl = (funct3 == 3'b000 && funct7[5]) ? c_ALU_SUB : w_alu_f3;
        end
        S_EXECI: begin
          ALUSrcA    = 2'b10;
          ALUSrcB    = 2'b01;
          ALUControl = w_alu_f3;
        end
        S_ALUWB: RegWrite = 1'b1;
        S_EXECJALR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        S_JAL: begin
          PCWrite = 1'b1;
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
        end
        S_BRANCH: begin
          ALUSrcA    = 2'b10;
          ALUControl = c_ALU_SUB;
          PCWrite    = w_taken;
        end
        S_LUI: begin
          ImmSrc    = c_IMM_U;
          ResultSrc = 2'b11;
          RegWrite  = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_multicycle_controller
// Brief   : Directed self-checking bench for multicycle_controller.
// Revision: 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero, neg, mem_ready;

  logic       pcw1, adr1, mw1, irw1, rw1, h1;
  logic [1:0] rs1, sa1, sb1;
  logic [2:0] alu1, imm1;
  logic       pcw0, adr0, mw0, irw0, rw0, h0;
  logic [1:0] rs0, sa0, sb0;
  logic [2:0] alu0, imm0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.ILLEGAL_HALT(1'b1)) u_dut_halt (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .neg(neg), .mem_ready(mem_ready),
    .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(mw1), .IRWrite(irw1),
    .ResultSrc(rs1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUControl(alu1),
    .ImmSrc(imm1), .RegWrite(rw1), .halted(h1)
  );

  multicycle_controller #(.ILLEGAL_HALT(1'b0)) u_dut_nop (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .neg(neg), .mem_ready(mem_ready),
    .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0), .IRWrite(irw0),
    .ResultSrc(rs0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ALUControl(alu0),
    .ImmSrc(imm0), .RegWrite(rw0), .halted(h0)
  );

  // Packed view: {PCW,Adr,MW,IRW,RS[2],SA[2],SB[2],ALU[3],Imm[3],RW,halted}
  logic [17:0] w_o1, w_o0;
  assign w_o1 = {pcw1, adr1, mw1, irw1, rs1, sa1, sb1, alu1, imm1, rw1, h1};
  assign w_o0 = {pcw0, adr0, mw0, irw0, rs0, sa0, sb0, alu0, imm0, rw0, h0};

  function automatic logic [17:0] ov(input logic pcw, input logic adr,
                                     input logic mw, input logic irw,
                                     input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] alu,
                                     input logic [2:0] imm, input logic rw,
                                     input logic h);
    return {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, h};
  endfunction

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  // Check the halting instance this cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [17:0] exp);
    #1;
    chk(tag, w_o1, exp);
    @(posedge clk);
    #1;
  endtask

  logic [17:0] e_zero, e_fetch, e_fstall, e_dec, e_decj, e_execr_add, e_execr_sub;
  logic [17:0] e_aluwb, e_memadr_lw, e_memadr_sw, e_memread, e_memwb, e_memwrite;
  logic [17:0] e_br_t, e_br_n, e_execjalr, e_jal, e_lui, e_halt;

  initial begin
    e_zero      = '0;
    e_fetch     = ov(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0);
    e_fstall    = ov(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0);
    e_dec       = ov(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b010, 0, 0);
    e_decj      = ov(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b011, 0, 0);
    e_execr_add = ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0, 0);
    e_execr_sub = ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0, 0);
    e_aluwb     = ov(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0);
    e_memadr_lw = ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0);
    e_memadr_sw = ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0, 0);
    e_memread   = ov(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0);
    e_memwb     = ov(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0);
    e_memwrite  = ov(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0);
    e_br_t      = ov(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0, 0);
    e_br_n      = ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0, 0);
    e_execjalr  = ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0);
    e_jal       = ov(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0, 0);
    e_lui       = ov(0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100, 1, 0);
    e_halt      = ov(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 1);

    rst = 1'b1; opcode = '0; funct3 = '0; funct7 = '0;
    zero = 1'b0; neg = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    cyc("reset0", e_zero);
    cyc("reset1", e_zero);

    // add then sub
    rst = 1'b0; opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'h00;
    cyc("add_fetch", e_fetch);
    cyc("add_decode", e_dec);
    cyc("add_execr", e_execr_add);
    cyc("add_aluwb", e_aluwb);
    funct7 = 7'h20;
    cyc("sub_fetch", e_fetch);
    cyc("sub_decode", e_dec);
    cyc("sub_execr", e_execr_sub);
    cyc("sub_aluwb", e_aluwb);

    // lw with three MEMREAD stall cycles
    opcode = 7'b0000011; funct3 = 3'b010;
    cyc("lw_fetch", e_fetch);
    cyc("lw_decode", e_dec);
    cyc("lw_memadr", e_memadr_lw);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw_memread_stall", e_memread);
    mem_ready = 1'b1;
    cyc("lw_memread_done", e_memread);
    cyc("lw_memwb", e_memwb);

    // branches
    opcode = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
    cyc("beq_fetch", e_fetch);
    cyc("beq_decode", e_dec);
    cyc("beq_taken", e_br_t);
    zero = 1'b0;
    cyc("beq2_fetch", e_fetch);
    cyc("beq2_decode", e_dec);
    cyc("beq_not_taken", e_br_n);
    funct3 = 3'b100; neg = 1'b1;
    cyc("blt_fetch", e_fetch);
    cyc("blt_decode", e_dec);
    cyc("blt_taken", e_br_t);
    funct3 = 3'b101;
    cyc("bge_fetch", e_fetch);
    cyc("bge_decode", e_dec);
    cyc("bge_not_taken", e_br_n);
    neg = 1'b0;

    // jalr with one fetch stall
    opcode = 7'b1100111; funct3 = 3'b000; mem_ready = 1'b0;
    cyc("jalr_fetch_stall", e_fstall);
    mem_ready = 1'b1;
    cyc("jalr_fetch", e_fetch);
    cyc("jalr_decode", e_dec);
    cyc("jalr_execjalr", e_execjalr);
    cyc("jalr_jal", e_jal);
    cyc("jalr_aluwb", e_aluwb);
    cyc("jalr_back_fetch", e_fetch);

    // jal: decode selects J immediate
    opcode = 7'b1101111;
    cyc("jal_decode", e_decj);
    cyc("jal_jal", e_jal);
    cyc("jal_aluwb", e_aluwb);

    // lui
    opcode = 7'b0110111;
    cyc("lui_fetch", e_fetch);
    cyc("lui_decode", e_dec);
    cyc("lui_lui", e_lui);

    // sw interrupted by reset while MemWrite is pending
    opcode = 7'b0100011; funct3 = 3'b010;
    cyc("sw_fetch", e_fetch);
    cyc("sw_decode", e_dec);
    cyc("sw_memadr", e_memadr_sw);
    mem_ready = 1'b0;
    cyc("sw_memwrite", e_memwrite);
    rst = 1'b1;
    cyc("sw_reset_drop", e_zero);
    rst = 1'b0; mem_ready = 1'b1;
    cyc("post_reset_fetch", e_fetch);

    // illegal opcode: one instance halts, the other resumes fetching
    opcode = 7'h7F;
    cyc("ill_decode", e_dec);
    #1;
    chk("ill_halted", w_o1, e_halt);
    chk("ill_nop_fetch", w_o0, e_fetch);
    @(posedge clk); #1;
    cyc("ill_halt_sticky", e_halt);
    rst = 1'b1;
    cyc("ill_reset", e_zero);
    rst = 1'b0;
    cyc("ill_recover", e_fetch);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
